hydration_timer: RTL

//  Upstream stage of the VGA display block. It debounces the four bottle-level

---
 rtl/hydration_timer_if.sv | 41 ++++
 rtl/hydration_timer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hydration_timer_if.sv
// Signal bundle between the hydration timer and its consumer (VGA display block).
// The master drives the sensor inputs and interval select; the slave (timer) drives
// the level, countdown digits and alarm/empty/buzzer indications.
interface hydration_timer_if;
  logic [3:0] level_raw;
  logic [1:0] interval_sel;
  logic [2:0] level;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       alarm;
  logic       empty;
  logic       buzzer;

  modport master (
    output level_raw,
    output interval_sel,
    input  level,
    input  min_tens,
    input  min_ones,
    input  sec_tens,
    input  sec_ones,
    input  alarm,
    input  empty,
    input  buzzer
  );

  modport slave (
    input  level_raw,
    input  interval_sel,
    output level,
    output min_tens,
    output min_ones,
    output sec_tens,
    output sec_ones,
    output alarm,
    output empty,
    output buzzer
  );
endinterface

// File: rtl/hydration_timer.sv
// Hydration timer: debounces four bottle-level sensors into a 0..4 fill level, runs a
// mm:ss BCD drink-reminder countdown and raises alarm/empty/buzzer indications.
// Optional feature macro: BUZZER_PULSE_EN -- when defined the buzzer beeps at 1 Hz
// (50% duty) instead of sounding continuously.
module hydration_timer #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned BASE_SEC     = 900
) (
  input logic             clk,
  input logic             reset,
  hydration_timer_if.slave bus
);

  localparam int unsigned TickW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DbW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  // Seconds -> {min_tens, min_ones, sec_tens, sec_ones} in BCD.
  function automatic logic [15:0] to_mmss(input int unsigned secs);
    int unsigned m;
    int unsigned s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // One-second BCD decrement with borrow; 00:00 is sticky.
  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = d;
    if (d != 16'h0000) begin
      if (so != 4'd0) begin
        so = so - 4'd1;
      end else begin
        so = 4'd9;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = 4'd5;
          if (mo != 4'd0) begin
            mo = mo - 4'd1;
          end else begin
            mo = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  localparam logic [15:0] Reload0 = to_mmss(1 * BASE_SEC);
  localparam logic [15:0] Reload1 = to_mmss(2 * BASE_SEC);
  localparam logic [15:0] Reload2 = to_mmss(3 * BASE_SEC);
  localparam logic [15:0] Reload3 = to_mmss(4 * BASE_SEC);

  typedef enum logic [1:0] {StRun, StAlarm, StEmpty} state_e;

  logic [3:0]     sync1_q, sync2_q, db_q;
  logic [DbW-1:0] db_cnt_q [4];
  logic [2:0]     level_d, level_q, level_prev_q;
  logic [1:0]     sel_q;
  logic [TickW-1:0] tick_cnt_q;
  logic           tick;
  logic [15:0]    reload_val;
  logic [15:0]    digits_d, digits_q;
  state_e         state_d, state_q;
  logic           reload;
  logic           drink;
  logic           sel_chg;
  logic           alarm;
  logic           empty;

  // Reload value for the currently selected interval.
  always_comb begin
    reload_val = Reload0;
    case (bus.interval_sel)
      2'd0:    reload_val = Reload0;
      2'd1:    reload_val = Reload1;
      2'd2:    reload_val = Reload2;
      default: reload_val = Reload3;
    endcase
  end

  // Two-flop synchroniser for the asynchronous sensor bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.level_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count while the synced bit disagrees with the accepted value;
  // any flip of the synced bit either restarts the count or ends the disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYC - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Fill level is the plain popcount of the debounced bits.
  always_comb begin
    level_d = {2'b00, db_q[0]} + {2'b00, db_q[1]} + {2'b00, db_q[2]} + {2'b00, db_q[3]};
  end

  // Registered level, its previous value (for drink detection) and the interval select.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q      <= '0;
      level_prev_q <= '0;
      sel_q        <= bus.interval_sel;
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      sel_q        <= bus.interval_sel;
    end
  end

  assign tick = (tick_cnt_q == TickW'(CLK_HZ - 1));

  // One-second tick counter; restarts with every reload so a fresh interval is full length.
  always_ff @(posedge clk) begin
    if (reset || reload || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Next-state and countdown logic; priority is empty > drink/select change > expiry > tick.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    reload   = 1'b0;
    drink    = (level_q < level_prev_q);
    sel_chg  = (sel_q != bus.interval_sel);
    case (state_q)
      StRun: begin
        if (level_q == 3'd0) begin
          state_d = StEmpty;
        end else if (drink || sel_chg) begin
          reload = 1'b1;
        end else if (tick) begin
          if (digits_q == 16'h0000) state_d = StAlarm;
          else digits_d = bcd_dec(digits_q);
        end
      end
      StAlarm: begin
        if (level_q == 3'd0) begin
          state_d = StEmpty;
        end else if (drink) begin
          state_d = StRun;
          reload  = 1'b1;
        end
      end
      StEmpty: begin
        if (level_q != 3'd0) begin
          state_d = StRun;
          reload  = 1'b1;
        end
      end
      default: begin
        state_d = StRun;
        reload  = 1'b1;
      end
    endcase
    if (reload) digits_d = reload_val;
  end

  // State and digit registers; reset loads the interval currently selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      digits_q <= reload_val;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
    end
  end

  assign alarm = (state_q == StAlarm);
  assign empty = (state_q == StEmpty);

`ifdef BUZZER_PULSE_EN
  localparam int unsigned HalfCyc = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int unsigned HalfW   = (HalfCyc > 1) ? $clog2(HalfCyc) : 1;

  logic [HalfW-1:0] half_cnt_q;
  logic             phase_q;

  // Free-running half-second phase that gates the buzzer into a 1 Hz beep.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else if (half_cnt_q == HalfW'(HalfCyc - 1)) begin
      half_cnt_q <= '0;
      phase_q    <= ~phase_q;
    end else begin
      half_cnt_q <= half_cnt_q + 1'b1;
    end
  end

  assign bus.buzzer = (alarm | empty) & phase_q;
`else
  assign bus.buzzer = alarm | empty;
`endif

  assign bus.level    = level_q;
  assign bus.min_tens = digits_q[15:12];
  assign bus.min_ones = digits_q[11:8];
  assign bus.sec_tens = digits_q[7:4];
  assign bus.sec_ones = digits_q[3:0];
  assign bus.alarm    = alarm;
  assign bus.empty    = empty;

endmodule
